// File: rtl/core_mem_if_pkg.sv
// core_mem_if_pkg: shared types and defaults for the core memory interface
package core_mem_if_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} gnt_e;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W = 4;
endpackage

// File: rtl/core_mem_if_arb.sv
// core_mem_if_arb: combinational fetch/data arbiter
//   if_req, d_req : pending requests
//   last_grant    : requestor served by the previous transaction
//   grant         : winner, meaningful only while some request is pending
module core_mem_if_arb
  import core_mem_if_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic if_req,
  input  logic d_req,
  input  gnt_e last_grant,
  output gnt_e grant
);
  // data normally wins; in fair mode fetch takes its turn right after a data access
  always_comb grant = (d_req && !(FAIR != 0 && last_grant == GNT_D && if_req)) ? GNT_D : GNT_IF;
endmodule

// File: rtl/core_mem_if.sv
// core_mem_if: arbitrated single-port memory interface for fetch and data requestors
//   if_req/if_addr -> if_ack/if_rdata           : instruction fetch port
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata  : data load/store port
//   mem_addr/mem_wdata/mem_we, mem_rdata        : registered external bus
//   busy                                        : transaction in ACCESS or RESP
module core_mem_if
  import core_mem_if_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1,
  parameter int FAIR        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_e             state_q, state_d;
  gnt_e               gnt_q, gnt_d, last_q, last_d, arb_gnt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               st_q, st_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  core_mem_if_arb #(.FAIR(FAIR)) u_arb (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_grant(last_q),
    .grant     (arb_gnt)
  );
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: if (if_req || d_req) begin
        state_d = ACCESS;
        gnt_d   = arb_gnt;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        st_d    = arb_gnt == GNT_D && d_we;
        we_d    = arb_gnt == GNT_D && d_we;
        addr_d  = arb_gnt == GNT_D ? d_addr : if_addr;
        wdata_d = arb_gnt == GNT_D ? d_wdata : wdata_q;
      end
      ACCESS: if (cnt_q == '0) begin
        state_d    = RESP;
        if_rdata_d = gnt_q == GNT_IF ? mem_rdata : if_rdata_q;
        d_rdata_d  = gnt_q == GNT_D && !st_q ? mem_rdata : d_rdata_q;
      end else cnt_d = cnt_q - 1'b1;
      RESP: begin
        state_d = IDLE;
        last_d  = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      last_q     <= GNT_IF;
      cnt_q      <= '0;
      st_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = state_q != IDLE;
  assign if_ack    = state_q == RESP && gnt_q == GNT_IF;
  assign d_ack     = state_q == RESP && gnt_q == GNT_D;
endmodule

// File: tb/tb_core_mem_if.sv
// tb_core_mem_if: transaction-timed reference model checks for three interface configurations
module tb_core_mem_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int ndone = 0;
  task automatic chk(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s inst%0d got=%h exp=%h", n, g, a, e);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = g == 0 ? 1 : g == 1 ? 0 : 15;
    localparam int F = g == 1 ? 0 : 1;
    localparam int ACK_LAT = g == 0 ? 3 : g == 1 ? 2 : 17;
    localparam int SPACING = g == 0 ? 4 : g == 1 ? 3 : 18;
    localparam logic [3:0] ORD = g == 1 ? 4'b1111 : 4'b0101;
    logic rst, if_req, d_req, d_we, if_ack, d_ack, mem_we, busy;
    logic [23:0] if_addr, d_addr, mem_addr;
    logic [15:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata, fixed_rd;
    core_mem_if #(.ADDR_W(24), .DATA_W(16), .WAIT_CYCLES(W), .FAIR(F)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );
    int cyc, t0;
    bit act, t_d, t_we, last_d, if_done, d_done;
    logic [23:0] e_addr;
    logic [15:0] e_wd, e_ifr, e_dr;
    bit ack_who[$];
    int ack_at[$];
    task automatic model_reset();
      act = 0; last_d = 0; if_done = 0; d_done = 0;
      e_addr = '0; e_wd = '0; e_ifr = '0; e_dr = '0;
    endtask
    task automatic cycle(input int mode);
      bit gd;
      @(posedge clk);
      cyc++;
      if (act && cyc == t0 + W + 2) begin
        if (!t_d) e_ifr = mem_rdata;
        else if (!t_we) e_dr = mem_rdata;
      end
      if ((!act || cyc - 1 > t0 + W + 2) && (if_req || d_req)) begin
        gd = d_req && !(F != 0 && last_d && if_req);
        act = 1; t0 = cyc - 1; t_d = gd; t_we = gd && d_we; last_d = gd;
        e_addr = gd ? d_addr : if_addr;
        if (gd) e_wd = d_wdata;
      end
      #1;
      mem_rdata = mode == 3 ? fixed_rd : 16'($urandom);
      case (mode)
        0: begin
          if (if_done) begin if_req = 1'($urandom_range(0, 1)); if_addr = 24'($urandom); end
          else if (!if_req && $urandom_range(0, 3) == 0) begin if_req = 1; if_addr = 24'($urandom); end
          if (d_done || (!d_req && $urandom_range(0, 3) == 0)) begin
            d_req = d_done ? 1'($urandom_range(0, 1)) : 1'b1;
            d_we = 1'($urandom); d_addr = 24'($urandom); d_wdata = 16'($urandom);
          end
        end
        1: begin
          if_req = 1; d_req = 1; d_we = 0;
          if (if_done) if_addr = 24'($urandom);
          if (d_done) d_addr = 24'($urandom);
        end
        2: begin if_req = 0; d_req = 0; end
        default: begin
          if (if_done) if_req = 0;
          if (d_done) d_req = 0;
        end
      endcase
      @(negedge clk);
      chk("busy", g, 32'(busy), 32'(act && cyc >= t0 + 1 && cyc <= t0 + W + 2));
      chk("mem_we", g, 32'(mem_we), 32'(act && t_we && cyc == t0 + 1));
      chk("if_ack", g, 32'(if_ack), 32'(act && !t_d && cyc == t0 + W + 2));
      chk("d_ack", g, 32'(d_ack), 32'(act && t_d && cyc == t0 + W + 2));
      chk("mem_addr", g, 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", g, 32'(mem_wdata), 32'(e_wd));
      chk("if_rdata", g, 32'(if_rdata), 32'(e_ifr));
      chk("d_rdata", g, 32'(d_rdata), 32'(e_dr));
      if_done = if_ack; d_done = d_ack;
      if (if_ack || d_ack) begin ack_who.push_back(d_ack); ack_at.push_back(cyc); end
    endtask
    task automatic dir(input bit fi, input bit di, input bit we, input logic [23:0] a,
                       input logic [15:0] wd, input logic [15:0] rd, input int max_cyc,
                       output int lat, output int wec, output logic [23:0] a1, output logic [15:0] wd1);
      int c0;
      lat = -1; wec = 0; a1 = '0; wd1 = '0;
      if_req = fi; d_req = di; d_we = we; d_wdata = wd;
      if (fi) if_addr = a;
      if (di) d_addr = a;
      fixed_rd = rd; mem_rdata = rd;
      c0 = cyc;
      for (int k = 0; k < max_cyc && lat < 0; k++) begin
        cycle(3);
        if (cyc == c0 + 1) begin a1 = mem_addr; wd1 = mem_wdata; end
        wec += int'(mem_we);
        if (if_ack || d_ack) lat = cyc - c0;
      end
    endtask
    initial begin
      int lat, wec, c0;
      logic [23:0] a1;
      logic [15:0] wd1;
      rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; fixed_rd = '0; cyc = 0; t0 = 0; t_d = 0; t_we = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", g, 32'(busy), 32'd0);
      chk("rst_addr", g, 32'(mem_addr), 32'd0);
      chk("rst_acks", g, 32'({if_ack, d_ack, mem_we}), 32'd0);
      rst = 0;
      c0 = cyc + 1;
      for (int k = 0; k < 200 && ack_who.size() < 4; k++) cycle(1);
      chk("n_grants", g, 32'(ack_who.size()), 32'd4);
      for (int i = 0; i < 4; i++)
        if (i < ack_who.size()) chk("grant_order", g, 32'(ack_who[i]), 32'(ORD[i]));
      if (ack_at.size() >= 2) begin
        chk("first_lat", g, 32'(ack_at[0] - c0), 32'(ACK_LAT));
        chk("b2b_spacing", g, 32'(ack_at[1] - ack_at[0]), 32'(SPACING));
      end
      repeat (20) cycle(2);
      dir(0, 1, 1, 24'h0000AA, 16'h1234, 16'h0000, 1, lat, wec, a1, wd1);
      chk("abort_we_before", g, 32'(mem_we), 32'd1);
      #1 rst = 1;
      #1;
      chk("abort_we", g, 32'(mem_we), 32'd0);
      chk("abort_busy", g, 32'(busy), 32'd0);
      chk("abort_bus", g, 32'({mem_addr, mem_wdata}), 32'd0);
      chk("abort_acks", g, 32'({if_ack, d_ack}), 32'd0);
      chk("abort_rdata", g, 32'({if_rdata, d_rdata}), 32'd0);
      if_req = 0; d_req = 0;
      model_reset();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 0;
      repeat (3) cycle(2);
      dir(0, 1, 1, 24'h0000FF, 16'h8000, 16'h5555, 40, lat, wec, a1, wd1);
      chk("st_lat", g, 32'(lat), 32'(ACK_LAT));
      chk("st_we_cnt", g, 32'(wec), 32'd1);
      chk("st_wdata", g, 32'(wd1), 32'h8000);
      chk("st_addr", g, 32'(a1), 32'h0000FF);
      chk("st_rdata", g, 32'(d_rdata), 32'd0);
      repeat (2) cycle(2);
      dir(1, 0, 0, 24'h000010, 16'h0000, 16'h3730, 40, lat, wec, a1, wd1);
      chk("if_lat", g, 32'(lat), 32'(ACK_LAT));
      chk("if_we_cnt", g, 32'(wec), 32'd0);
      chk("if_addr", g, 32'(a1), 32'h000010);
      chk("if_data", g, 32'(if_rdata), 32'h3730);
      repeat (2) cycle(2);
      dir(0, 1, 0, 24'h000123, 16'h0000, 16'hA5A5, 40, lat, wec, a1, wd1);
      chk("ld_lat", g, 32'(lat), 32'(ACK_LAT));
      chk("ld_data", g, 32'(d_rdata), 32'hA5A5);
      repeat (2) cycle(2);
      repeat (1500) cycle(0);
      ndone++;
    end
  end
  initial begin
    for (int k = 0; k < 30000 && ndone < 3; k++) @(posedge clk);
    if (ndone < 3) begin
      total++;
      bad++;
      $display("FAIL timeout done=%0d required=3", ndone);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
